grant_ack_tracker: RTL and testbench
====================================

GRANT_ACK_TRACKER -- requirements
Module: grant_ack_tracker

Interface
REQ-001 Parameter SRC_W, 4, width of TileLink source IDs.
REQ-002 Parameter GRANT_OPC, 3'd4, D-channel opcode driven for Grant.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid / req_ready  in / out  1 / 1  grant request handshake from the directory.
REQ-006 req_source / req_param  in  SRC_W / 2  requester source and cap param.
REQ-007 alloc_req  out  1  one-cycle request pulse to the sink ID manager.
REQ-008 alloc_gnt / alloc_sink_id  in  1 / 4  manager grant and offered sink ID.
REQ-009 dealloc_req / dealloc_sink_id  out  1 / 4  one-cycle pulse freeing a sink ID.
REQ-010 d_valid / d_ready  out / in  1 / 1  D-channel handshake.
REQ-011 d_opcode / d_param / d_source / d_sink  out  3 / 2 / SRC_W / 4  D-channel Grant fields.
REQ-012 e_valid / e_ready / e_sink  in / out / in  1 / 1 / 4  E-channel GrantAck.
REQ-013 outstanding  out  5  number of Grants sent and not yet acked, range 0..16.
REQ-014 err_spurious_ack  out  1  sticky flag, set on a GrantAck for a non-pending sink.

Function
REQ-015 FSM states: IDLE, ALLOC, WAIT_GNT, SEND_D.
- IDLE: req_ready=1. On req_valid, latch source/param and go to ALLOC.
REQ-016 ALLOC:
- assert alloc_req for exactly this cycle;
- latch alloc_sink_id into sink_r in the same cycle;
- go to WAIT_GNT.
REQ-017 WAIT_GNT:
- alloc_gnt=1: go to SEND_D.
- alloc_gnt=0 (manager full): return to ALLOC (retry every 2 cycles, no limit).
REQ-018 SEND_D:
- d_valid=1, d_opcode=GRANT_OPC, d_param/d_source latched, d_sink=sink_r;
- fields held stable until d_ready.
- On the d_valid&&d_ready cycle: set pending[sink_r], go to IDLE.
REQ-019 req_ready is 1 only in IDLE; at most one Grant is in flight through the FSM.
REQ-020 Tracking table: 16 entries, each a pending bit plus stored source.
REQ-021 e_ready is constantly 1.
REQ-022 GrantAck with e_valid && pending[e_sink]:
- clear pending[e_sink];
- pulse dealloc_req with dealloc_sink_id=e_sink in the same cycle, combinational from e_valid.
REQ-023 GrantAck with e_valid && !pending[e_sink]:
- no dealloc;
- set err_spurious_ack, which holds until reset.
REQ-024 GrantAck in the same cycle as the D handshake for the same sink:
- the ack is spurious (pending not yet set);
- the D handshake still sets pending.
REQ-025 GrantAck for a different sink in the same cycle as the D handshake: both take effect.
REQ-026 outstanding = popcount(pending), registered, updated the cycle after any pending change.
- Simultaneous set and clear leave it unchanged.
REQ-027 dealloc_req and alloc_req may assert in the same cycle; no interlock.

Reset
REQ-028 During rst:
- FSM=IDLE, pending=0, outstanding=0, err_spurious_ack=0;
- alloc_req=0, dealloc_req=0, d_valid=0, req_ready=0;
- latched fields=0.
REQ-029 After rst deasserts: req_ready=1 from the first clk edge; e_ready=1.
REQ-030 Reset mid-operation (any state): all pending Grants are abandoned without a dealloc pulse; the sink ID manager is reset by the same rst.

Verification
REQ-031 Single Grant:
- req source=3, param=1; manager offers ID 0 with grant.
- D: opcode=4, param=1, source=3, sink=0; outstanding=1 after handshake.
- e_sink=0 -> dealloc_req pulse with id 0; outstanding=0.
REQ-032 D backpressure: d_ready held low 5 cycles -> d_valid and all fields stable; req_ready=0 throughout.
REQ-033 Manager full:
- 16 Grants outstanding (outstanding=16); 17th request -> alloc_req pulses every 2 cycles, no D.
- GrantAck for sink 5 -> dealloc; next alloc_gnt -> D issued with the newly offered ID.
REQ-034 Spurious ack: e_sink=9 with no pending entry -> no dealloc_req, err_spurious_ack=1 and held.
REQ-035 Simultaneous events:
- D handshake for sink 2 with GrantAck for sink 7 (pending) in the same cycle;
- pending[2]=1, pending[7]=0, dealloc id 7, outstanding unchanged.
REQ-036 Reset in SEND_D -> d_valid=0 immediately, outstanding=0, FSM IDLE.

Source files
------------

// File: rtl/grant_ack_tracker.sv
// ---------------------------------------------------------------------------
// grant_ack_tracker
//
// Issues TileLink Grant messages on the D channel on behalf of the directory
// and tracks them until the requester returns a GrantAck on the E channel.
// Each Grant needs a sink ID, which is borrowed from an external sink ID
// manager and returned to it when the matching GrantAck arrives.
//
// Flow of one Grant:
//   IDLE      accept a request (source, cap param)
//   ALLOC     ask the manager for a sink ID, capture the offered ID
//   WAIT_GNT  manager confirms (go to SEND_D) or is full (retry ALLOC)
//   SEND_D    present the Grant until the D handshake, then mark it pending
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   req_valid/req_ready       grant request handshake from the directory
//   req_source, req_param     requester source ID and cap param
//   alloc_req                 one-cycle request pulse to the sink ID manager
//   alloc_gnt, alloc_sink_id  manager grant and the sink ID it offers
//   dealloc_req/_sink_id      one-cycle pulse returning a sink ID
//   d_valid/d_ready           D-channel handshake
//   d_opcode/param/source/sink  D-channel Grant fields
//   e_valid/e_ready/e_sink    E-channel GrantAck (always accepted)
//   outstanding               Grants sent and not yet acked (0..16)
//   err_spurious_ack          sticky: a GrantAck named a non-pending sink
// ---------------------------------------------------------------------------
module grant_ack_tracker #(
    parameter int         SRC_W     = 4,
    parameter logic [2:0] GRANT_OPC = 3'd4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SRC_W-1:0] req_source,
    input  logic [1:0]       req_param,

    output logic             alloc_req,
    input  logic             alloc_gnt,
    input  logic [3:0]       alloc_sink_id,

    output logic             dealloc_req,
    output logic [3:0]       dealloc_sink_id,

    output logic             d_valid,
    input  logic             d_ready,
    output logic [2:0]       d_opcode,
    output logic [1:0]       d_param,
    output logic [SRC_W-1:0] d_source,
    output logic [3:0]       d_sink,

    input  logic             e_valid,
    output logic             e_ready,
    input  logic [3:0]       e_sink,

    output logic [4:0]       outstanding,
    output logic             err_spurious_ack
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALLOC    = 2'd1,
        WAIT_GNT = 2'd2,
        SEND_D   = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic             live_r;      // low during reset and until the first clock edge after it
    logic [SRC_W-1:0] source_r;
    logic [1:0]       param_r;
    logic [3:0]       sink_r;
    logic [15:0]      pending;

    logic             req_fire;
    logic             d_fire;
    logic             ack_hit;
    logic [15:0]      pend_set;
    logic [15:0]      pend_clr;

    function automatic logic [4:0] count_ones(input logic [15:0] v);
        logic [4:0] sum;
        sum = 5'd0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + {4'd0, v[i]};
        end
        return sum;
    endfunction

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            live_r <= 1'b0;
        end else begin
            state  <= state_nx;
            live_r <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and Moore outputs
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        alloc_req = 1'b0;
        d_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                // Held off until the first edge after reset so the directory
                // never sees a ready that the register state cannot back up.
                req_ready = live_r;
                if (req_valid && live_r) begin
                    state_nx = ALLOC;
                end
            end
            ALLOC: begin
                alloc_req = 1'b1;
                state_nx  = WAIT_GNT;
            end
            WAIT_GNT: begin
                // A refusal means the manager is full; keep asking every
                // other cycle until an ID frees up.
                state_nx = alloc_gnt ? SEND_D : ALLOC;
            end
            SEND_D: begin
                d_valid = 1'b1;
                if (d_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign req_fire = req_valid && req_ready;
    assign d_fire   = d_valid && d_ready;

    // -----------------------------------------------------------------------
    // Latched Grant fields. They only change outside SEND_D, which keeps the
    // D-channel payload stable under backpressure.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            source_r <= '0;
            param_r  <= '0;
            sink_r   <= '0;
        end else begin
            if (req_fire) begin
                source_r <= req_source;
                param_r  <= req_param;
            end
            // Captured on every ALLOC attempt; only the ID offered on the
            // attempt that the manager confirms survives into SEND_D.
            if (state == ALLOC) begin
                sink_r <= alloc_sink_id;
            end
        end
    end

    assign d_opcode = GRANT_OPC;
    assign d_param  = param_r;
    assign d_source = source_r;
    assign d_sink   = sink_r;

    // -----------------------------------------------------------------------
    // Pending table and GrantAck handling
    // -----------------------------------------------------------------------
    // The ack is judged against the pre-edge table, so an ack that lands in
    // the same cycle as the D handshake for its own sink is spurious, while
    // the handshake still marks that sink pending.
    assign e_ready         = 1'b1;
    assign ack_hit         = e_valid && pending[e_sink];
    assign dealloc_req     = ack_hit;
    assign dealloc_sink_id = e_sink;

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (d_fire) begin
            pend_set[sink_r] = 1'b1;
        end
        if (ack_hit) begin
            pend_clr[e_sink] = 1'b1;
        end
    end

    // NOTE: the 16-entry table is reset explicitly; a reset mid-operation
    // must abandon every in-flight Grant, which the manager mirrors by
    // resetting on the same rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending          <= '0;
            outstanding      <= '0;
            err_spurious_ack <= 1'b0;
        end else begin
            pending     <= (pending & ~pend_clr) | pend_set;
            // Follows the table one cycle behind; a set and a clear in the
            // same cycle cancel out in the count.
            outstanding <= count_ones(pending);
            if (e_valid && !pending[e_sink]) begin
                err_spurious_ack <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grant_ack_tracker.sv
// ---------------------------------------------------------------------------
// tb_grant_ack_tracker
//
// Directed scenarios followed by a randomized mix of Grants and GrantAcks.
// Expected values come from a set-based model: a 16-bit pending set, a
// sticky error bit, and a sink ID manager stub that always offers its
// lowest free ID and confirms one cycle after an allocation request.
// ---------------------------------------------------------------------------
module tb_grant_ack_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready;
    logic [3:0] req_source;
    logic [1:0] req_param;
    logic       alloc_req, alloc_gnt;
    logic [3:0] alloc_sink_id;
    logic       dealloc_req;
    logic [3:0] dealloc_sink_id;
    logic       d_valid, d_ready;
    logic [2:0] d_opcode;
    logic [1:0] d_param;
    logic [3:0] d_source, d_sink;
    logic       e_valid, e_ready;
    logic [3:0] e_sink;
    logic [4:0] outstanding;
    logic       err_spurious_ack;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model
    logic [15:0] mdl_pend;
    logic        mdl_err;

    // Sink ID manager stub
    logic [15:0] mgr_used;
    logic        gnt_due;

    grant_ack_tracker #(.SRC_W(4), .GRANT_OPC(3'd4)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_source       (req_source),
        .req_param        (req_param),
        .alloc_req        (alloc_req),
        .alloc_gnt        (alloc_gnt),
        .alloc_sink_id    (alloc_sink_id),
        .dealloc_req      (dealloc_req),
        .dealloc_sink_id  (dealloc_sink_id),
        .d_valid          (d_valid),
        .d_ready          (d_ready),
        .d_opcode         (d_opcode),
        .d_param          (d_param),
        .d_source         (d_source),
        .d_sink           (d_sink),
        .e_valid          (e_valid),
        .e_ready          (e_ready),
        .e_sink           (e_sink),
        .outstanding      (outstanding),
        .err_spurious_ack (err_spurious_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    function automatic logic [3:0] lowest_free(input logic [15:0] used);
        logic [3:0] id;
        id = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (!used[i]) id = 4'(i);
        end
        return id;
    endfunction

    // Manager: tracks IDs handed out (D handshake) and returned (dealloc).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mgr_used <= '0;
        end else begin
            if (dealloc_req) mgr_used[dealloc_sink_id] <= 1'b0;
            if (d_valid && d_ready) mgr_used[d_sink] <= 1'b1;
        end
    end

    // Manager: offers its lowest free ID, confirms the cycle after alloc_req.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            alloc_gnt     <= 1'b0;
            gnt_due       <= 1'b0;
            alloc_sink_id <= 4'd0;
        end else begin
            alloc_gnt     <= gnt_due;
            gnt_due       <= alloc_req && (mgr_used != 16'hffff);
            alloc_sink_id <= lowest_free(mgr_used);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out();
        @(negedge clk);
        check("outstanding", outstanding, $countones(mdl_pend));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        d_ready = 1'b0;
        e_valid = 1'b0;
        #1;
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_alloc_req", alloc_req, 1'b0);
        check("rst_dealloc_req", dealloc_req, 1'b0);
        check("rst_outstanding", outstanding, 5'd0);
        check("rst_err", err_spurious_ack, 1'b0);
        check("rst_d_source", d_source, 4'd0);
        mdl_pend = '0;
        mdl_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("req_ready_after_rst", req_ready, 1'b1);
        check("e_ready_after_rst", e_ready, 1'b1);
    endtask

    // Leaves the bench at the negedge of the first ALLOC cycle.
    task automatic issue_req(input logic [3:0] src, input logic [1:0] prm);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_source = src;
        req_param = prm;
        @(negedge clk);
        req_valid = 1'b0;
        check("alloc_req_pulse", alloc_req, 1'b1);
    endtask

    task automatic wait_d(output int lat);
        lat = 0;
        while (d_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("d_valid_seen", d_valid, 1'b1);
    endtask

    task automatic check_d(input logic [3:0] src, input logic [1:0] prm, input logic [3:0] sink);
        check("d_opcode", d_opcode, 3'd4);
        check("d_param", d_param, prm);
        check("d_source", d_source, src);
        check("d_sink", d_sink, sink);
    endtask

    task automatic grant(input logic [3:0] src, input logic [1:0] prm, input int dwait);
        logic [3:0] sink;
        int lat;
        sink = lowest_free(mdl_pend);
        issue_req(src, prm);
        wait_d(lat);
        check("d_latency", lat, 2);
        check_d(src, prm, sink);
        for (int i = 0; i < dwait; i++) begin
            @(negedge clk);
            check("bp_d_valid", d_valid, 1'b1);
            check("bp_req_ready", req_ready, 1'b0);
            check_d(src, prm, sink);
        end
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        mdl_pend[sink] = 1'b1;
    endtask

    task automatic ack(input logic [3:0] sink);
        logic hit;
        hit = mdl_pend[sink];
        @(negedge clk);
        e_valid = 1'b1;
        e_sink = sink;
        #1;
        check("dealloc_req", dealloc_req, hit);
        if (hit) check("dealloc_id", dealloc_sink_id, sink);
        @(negedge clk);
        e_valid = 1'b0;
        if (hit) mdl_pend[sink] = 1'b0;
        else     mdl_err = 1'b1;
        check("err_spurious", err_spurious_ack, mdl_err);
    endtask

    initial begin
        logic [3:0] s;
        int lat;

        rst = 1'b1;
        req_valid = 1'b0; req_source = '0; req_param = '0;
        d_ready = 1'b0; e_valid = 1'b0; e_sink = '0;
        mdl_pend = '0; mdl_err = 1'b0;

        do_reset();

        // Single Grant: source 3, param 1, ID 0
        grant(4'd3, 2'd1, 0);
        chk_out();
        ack(4'd0);
        chk_out();

        // D backpressure for 5 cycles
        grant(4'd5, 2'd2, 5);
        chk_out();
        ack(4'd0);
        chk_out();

        // Spurious ack, flag holds
        ack(4'd9);
        repeat (3) @(negedge clk);
        check("err_held", err_spurious_ack, 1'b1);

        // Ack for the sink being granted in the same cycle: spurious, still pending
        do_reset();
        issue_req(4'd6, 2'd2);
        wait_d(lat);
        check_d(4'd6, 2'd2, 4'd0);
        d_ready = 1'b1; e_valid = 1'b1; e_sink = 4'd0;
        #1;
        check("same_sink_no_dealloc", dealloc_req, 1'b0);
        @(negedge clk);
        d_ready = 1'b0; e_valid = 1'b0;
        mdl_pend[0] = 1'b1; mdl_err = 1'b1;
        check("same_sink_err", err_spurious_ack, mdl_err);
        chk_out();

        // D handshake for sink 2 alongside ack for pending sink 7
        do_reset();
        for (int i = 0; i < 8; i++) grant(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 0);
        ack(4'd2);
        chk_out();
        issue_req(4'hA, 2'd3);
        wait_d(lat);
        check_d(4'hA, 2'd3, 4'd2);
        d_ready = 1'b1; e_valid = 1'b1; e_sink = 4'd7;
        #1;
        check("simul_dealloc", dealloc_req, 1'b1);
        check("simul_dealloc_id", dealloc_sink_id, 4'd7);
        @(negedge clk);
        d_ready = 1'b0; e_valid = 1'b0;
        mdl_pend[2] = 1'b1; mdl_pend[7] = 1'b0;
        check("simul_out_steady", outstanding, $countones(mdl_pend));
        chk_out();

        // Manager full: 16 outstanding, 17th request retries every 2 cycles
        do_reset();
        for (int i = 0; i < 16; i++) grant(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 0);
        chk_out();
        check("full_outstanding", outstanding, 5'd16);
        issue_req(4'hC, 2'd1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("retry_alloc_req", alloc_req, (i % 2) == 0);
            check("retry_no_d", d_valid, 1'b0);
        end
        ack(4'd5);
        wait_d(lat);
        check_d(4'hC, 2'd1, 4'd5);
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        mdl_pend[5] = 1'b1;
        chk_out();

        // Reset while in SEND_D abandons everything
        ack(4'd0);
        issue_req(4'd2, 2'd1);
        wait_d(lat);
        do_reset();
        chk_out();
        ack(4'd3);

        // Randomized mix
        for (int it = 0; it < 60; it++) begin
            if ($countones(mdl_pend) < 16 && $urandom_range(0, 1) == 1) begin
                grant(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                if (mdl_pend != 16'd0 && $urandom_range(0, 3) != 0) begin
                    do s = 4'($urandom_range(0, 15)); while (!mdl_pend[s]);
                end else begin
                    s = 4'($urandom_range(0, 15));
                end
                ack(s);
            end
            chk_out();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
